// File: rtl/traffic_light_ctrl_n_if.sv
// Signal bundle between the intersection controller and its surroundings.
// The master side drives requests and mode controls; the controller (slave) drives the lamp and status outputs.
interface traffic_light_ctrl_n_if #(
  parameter int NUM_PHASES = 4,
  parameter int PH_W       = 2
);
  logic                    enable;
  logic [NUM_PHASES-1:0]   ped_req;
  logic                    emg_req;
  logic [PH_W-1:0]         emg_phase;
  logic                    flash_mode;
  logic [3*NUM_PHASES-1:0] lights;
  logic [NUM_PHASES-1:0]   walk;
  logic [PH_W-1:0]         phase_idx;
  logic [2:0]              state;

  modport master (
    output enable, ped_req, emg_req, emg_phase, flash_mode,
    input  lights, walk, phase_idx, state
  );

  modport slave (
    input  enable, ped_req, emg_req, emg_phase, flash_mode,
    output lights, walk, phase_idx, state
  );
endinterface

// File: rtl/traffic_light_ctrl_n.sv
// Round-robin N-phase traffic light controller with pedestrian walk extension,
// emergency preemption and flashing-yellow maintenance mode; all outputs registered.
module traffic_light_ctrl_n #(
  parameter int NUM_PHASES = 4,
  parameter int PH_W       = 2,
  parameter int CNT_W      = 4,
  parameter int T_GREEN    = 7,
  parameter int T_YELLOW   = 2,
  parameter int T_ALLRED   = 1,
  parameter int T_PED      = 5
) (
  input logic                   clock,
  input logic                   reset,
  traffic_light_ctrl_n_if.slave bus
);

  typedef enum logic [2:0] {
    S_ALLRED = 3'd0,
    S_GREEN  = 3'd1,
    S_YELLOW = 3'd2,
    S_EMG    = 3'd3,
    S_FLASH  = 3'd4
  } state_t;

  if ((T_GREEN + T_PED - 1) >= (1 << CNT_W) || (T_YELLOW - 1) >= (1 << CNT_W) ||
      (T_ALLRED - 1) >= (1 << CNT_W)) begin : g_cnt_w_check
    $error("CNT_W too narrow for the configured dwell times");
  end
  if ((1 << PH_W) < NUM_PHASES || NUM_PHASES < 2) begin : g_ph_w_check
    $error("PH_W cannot index NUM_PHASES, or NUM_PHASES < 2");
  end

  localparam logic [CNT_W-1:0] RED_LAST = CNT_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0] GRN_LAST = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] PED_LAST = CNT_W'(T_GREEN + T_PED - 1);
  localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(T_YELLOW - 1);
  localparam logic [PH_W-1:0]  LAST_PH  = PH_W'(NUM_PHASES - 1);

  state_t                  st_q, st_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;
  logic [PH_W-1:0]         ph_q, ph_d, ph_nxt;
  logic [NUM_PHASES-1:0]   latch_q, latch_d, ped_clr;
  logic [NUM_PHASES-1:0]   walk_q, walk_d;
  logic                    tog_q, tog_d;
  logic                    first_q, first_d;
  logic [3*NUM_PHASES-1:0] lights_q, lights_d;
  logic                    emg_ok, grn_last;

  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign ph_nxt   = (ph_q == LAST_PH) ? '0 : ph_q + PH_W'(1);
  assign emg_ok   = bus.emg_req && (int'(bus.emg_phase) < NUM_PHASES);
  assign grn_last = (cnt_q == ((walk_q != '0) ? PED_LAST : GRN_LAST));

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    ph_d    = ph_q;
    walk_d  = walk_q;
    tog_d   = tog_q;
    first_d = first_q;
    ped_clr = '0;
    // Flash overrides everything and is entered even while timing is frozen.
    if (bus.flash_mode) begin
      if (st_q != S_FLASH) begin
        st_d   = S_FLASH;
        cnt_d  = '0;
        tog_d  = 1'b1;
        walk_d = '0;
      end else if (bus.enable) begin
        if (cnt_q == YEL_LAST) begin
          cnt_d = '0;
          tog_d = ~tog_q;
        end else begin
          cnt_d = cnt_inc;
        end
      end
    end else if (bus.enable) begin
      case (st_q)
        S_ALLRED: begin
          if (cnt_q == RED_LAST) begin
            cnt_d   = '0;
            first_d = 1'b0;
            if (emg_ok) begin
              st_d = S_EMG;
              ph_d = bus.emg_phase;
            end else begin
              st_d = S_GREEN;
              ph_d = first_q ? ph_q : ph_nxt;
              for (int i = 0; i < NUM_PHASES; i++) begin
                if (ph_d == PH_W'(i)) begin
                  walk_d[i]  = latch_q[i];
                  ped_clr[i] = 1'b1;
                end
              end
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_GREEN: begin
          if (emg_ok) begin
            cnt_d  = '0;
            walk_d = '0;
            st_d   = (bus.emg_phase == ph_q) ? S_EMG : S_YELLOW;
          end else if (grn_last) begin
            cnt_d  = '0;
            walk_d = '0;
            st_d   = S_YELLOW;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_YELLOW: begin
          if (cnt_q == YEL_LAST) begin
            cnt_d = '0;
            st_d  = S_ALLRED;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_EMG: begin
          if (!bus.emg_req) begin
            cnt_d = '0;
            st_d  = S_YELLOW;
          end
        end
        S_FLASH: begin
          st_d    = S_ALLRED;
          cnt_d   = '0;
          ph_d    = '0;
          first_d = 1'b1;
          walk_d  = '0;
        end
        default: begin
          st_d    = S_ALLRED;
          cnt_d   = '0;
          ph_d    = '0;
          first_d = 1'b1;
          walk_d  = '0;
        end
      endcase
    end
  end

  assign latch_d = (latch_q & ~ped_clr) | bus.ped_req;

  // Lamps are decoded from next-state values so they register on the same edge as state.
  always_comb begin
    lights_d = '0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      if (st_d == S_FLASH)
        lights_d[3*i +: 3] = {1'b0, tog_d, 1'b0};
      else if (ph_d == PH_W'(i) && (st_d == S_GREEN || st_d == S_EMG))
        lights_d[3*i +: 3] = 3'b001;
      else if (ph_d == PH_W'(i) && st_d == S_YELLOW)
        lights_d[3*i +: 3] = 3'b010;
      else
        lights_d[3*i +: 3] = 3'b100;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st_q     <= S_ALLRED;
      cnt_q    <= '0;
      ph_q     <= '0;
      latch_q  <= '0;
      walk_q   <= '0;
      tog_q    <= 1'b1;
      first_q  <= 1'b1;
      lights_q <= {NUM_PHASES{3'b100}};
    end else begin
      st_q     <= st_d;
      cnt_q    <= cnt_d;
      ph_q     <= ph_d;
      latch_q  <= latch_d;
      walk_q   <= walk_d;
      tog_q    <= tog_d;
      first_q  <= first_d;
      lights_q <= lights_d;
    end
  end

  assign bus.lights    = lights_q;
  assign bus.walk      = walk_q;
  assign bus.phase_idx = ph_q;
  assign bus.state     = st_q;

endmodule

// File: tb/tb_traffic_light_ctrl_n.sv
// Bench for traffic_light_ctrl_n: a 4-phase and a 3-phase instance share stimulus and
// are compared each cycle against a countdown-based schedule model, plus vector tables.
module tb_traffic_light_ctrl_n;
  localparam int TG = 7;
  localparam int TY = 2;
  localparam int TA = 1;
  localparam int TP = 5;

  logic       clock = 1'b0;
  logic       reset;
  logic       en, emg, fl;
  logic [3:0] ped;
  logic [1:0] eph;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clock = ~clock;

  traffic_light_ctrl_n_if #(.NUM_PHASES(4), .PH_W(2)) bus4 ();
  traffic_light_ctrl_n_if #(.NUM_PHASES(3), .PH_W(2)) bus3 ();

  assign bus4.enable     = en;
  assign bus4.ped_req    = ped;
  assign bus4.emg_req    = emg;
  assign bus4.emg_phase  = eph;
  assign bus4.flash_mode = fl;
  assign bus3.enable     = en;
  assign bus3.ped_req    = ped[2:0];
  assign bus3.emg_req    = emg;
  assign bus3.emg_phase  = eph;
  assign bus3.flash_mode = fl;

  traffic_light_ctrl_n dut4 (.clock(clock), .reset(reset), .bus(bus4));
  traffic_light_ctrl_n #(.NUM_PHASES(3)) dut3 (.clock(clock), .reset(reset), .bus(bus3));

  // Reference model: segment (0 red,1 green,2 yellow,3 emg,4 flash) with cycles left in it.
  int       m_seg[2], m_left[2], m_ph[2], m_tog[2];
  bit       m_first[2], m_won[2];
  bit [3:0] m_pend[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] lamp(input int st, input bit mine, input int tog);
    if (st == 4) return {1'b0, tog[0], 1'b0};
    if (mine && (st == 1 || st == 3)) return 3'b001;
    if (mine && st == 2) return 3'b010;
    return 3'b100;
  endfunction

  function automatic logic [31:0] pack_exp(input int n, input int st, input int ph,
                                           input logic [3:0] w, input int tog);
    logic [11:0] l;
    l = '0;
    for (int i = 0; i < n; i++) l[3*i +: 3] = lamp(st, i == ph, tog);
    return {11'b0, 3'(st), 2'(ph), w, l};
  endfunction

  function automatic logic [31:0] m_out(input int k);
    logic [3:0] w;
    w = '0;
    if (m_won[k]) w[m_ph[k]] = 1'b1;
    return pack_exp((k == 0) ? 4 : 3, m_seg[k], m_ph[k], w, m_tog[k]);
  endfunction

  function automatic logic [31:0] act4();
    return {11'b0, bus4.state, bus4.phase_idx, bus4.walk, bus4.lights};
  endfunction

  function automatic logic [31:0] act3();
    return {11'b0, bus3.state, bus3.phase_idx, 1'b0, bus3.walk, 3'b0, bus3.lights};
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_seg[k] = 0; m_left[k] = TA; m_ph[k] = 0; m_tog[k] = 1;
      m_first[k] = 1'b1; m_won[k] = 1'b0; m_pend[k] = '0;
    end
  endtask

  task automatic m_step();
    for (int k = 0; k < 2; k++) begin
      int n;
      bit ev;
      bit [3:0] pv;
      n  = (k == 0) ? 4 : 3;
      pv = (k == 0) ? ped : {1'b0, ped[2:0]};
      ev = emg && (int'(eph) < n);
      if (fl) begin
        if (m_seg[k] != 4) begin
          m_seg[k] = 4; m_left[k] = TY; m_tog[k] = 1; m_won[k] = 1'b0;
        end else if (en) begin
          m_left[k]--;
          if (m_left[k] == 0) begin m_tog[k] ^= 1; m_left[k] = TY; end
        end
      end else if (en) begin
        case (m_seg[k])
          4: begin m_seg[k] = 0; m_left[k] = TA; m_ph[k] = 0; m_first[k] = 1'b1; end
          0: begin
            m_left[k]--;
            if (m_left[k] == 0) begin
              if (ev) begin
                m_seg[k] = 3; m_ph[k] = int'(eph);
              end else begin
                if (!m_first[k]) m_ph[k] = (m_ph[k] + 1) % n;
                m_seg[k]  = 1;
                m_won[k]  = m_pend[k][m_ph[k]];
                m_pend[k][m_ph[k]] = 1'b0;
                m_left[k] = TG + (m_won[k] ? TP : 0);
              end
              m_first[k] = 1'b0;
            end
          end
          1: begin
            if (ev) begin
              m_won[k] = 1'b0; m_left[k] = TY;
              m_seg[k] = (int'(eph) == m_ph[k]) ? 3 : 2;
            end else begin
              m_left[k]--;
              if (m_left[k] == 0) begin m_seg[k] = 2; m_left[k] = TY; m_won[k] = 1'b0; end
            end
          end
          2: begin
            m_left[k]--;
            if (m_left[k] == 0) begin m_seg[k] = 0; m_left[k] = TA; end
          end
          default: if (!emg) begin m_seg[k] = 2; m_left[k] = TY; end
        endcase
      end
      m_pend[k] |= pv;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    m_step();
    @(negedge clock);
    chk("model4", act4(), m_out(0));
    chk("model3", act3(), m_out(1));
  endtask

  typedef struct {
    bit en; bit [3:0] ped; bit emg; bit [1:0] eph; bit fl; int cyc;
    int st; int ph; bit [3:0] w; int tog;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(input bit e, input bit [3:0] p, input bit em, input bit [1:0] ep,
                              input bit f, input int c, input int s, input int ph,
                              input bit [3:0] w, input int t);
    vec_t v;
    v.en = e; v.ped = p; v.emg = em; v.eph = ep; v.fl = f; v.cyc = c;
    v.st = s; v.ph = ph; v.w = w; v.tog = t;
    return v;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // default round: G7 Y2 R1 per phase
    tbl.push_back(mk(1, 0, 0, 0, 0,  1, 1, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0,  6, 1, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0,  1, 2, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0,  1, 2, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0,  1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0,  1, 1, 1, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 29, 0, 3, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0,  1, 1, 0, 0, 1));
    // pedestrian pulse for phase 1
    tbl.push_back(mk(1, 4'b0010, 0, 0, 0, 1, 1, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0,  8, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0,  1, 1, 1, 4'b0010, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 11, 1, 1, 4'b0010, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0,  1, 2, 1, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 22, 0, 3, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0,  1, 1, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 39, 0, 3, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0,  1, 1, 0, 0, 1));
    // emergency to phase 2 from third cycle of phase 0 green
    tbl.push_back(mk(1, 0, 0, 0, 0,  2, 1, 0, 0, 1));
    tbl.push_back(mk(1, 0, 1, 2, 0,  1, 2, 0, 0, 1));
    tbl.push_back(mk(1, 0, 1, 2, 0,  1, 2, 0, 0, 1));
    tbl.push_back(mk(1, 0, 1, 2, 0,  1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 1, 2, 0,  1, 3, 2, 0, 1));
    tbl.push_back(mk(1, 0, 1, 2, 0, 10, 3, 2, 0, 1));
    tbl.push_back(mk(1, 0, 1, 1, 0,  1, 3, 2, 0, 1));
    tbl.push_back(mk(1, 0, 0, 1, 0,  1, 2, 2, 0, 1));
    tbl.push_back(mk(1, 0, 0, 1, 0,  1, 2, 2, 0, 1));
    tbl.push_back(mk(1, 0, 0, 1, 0,  1, 0, 2, 0, 1));
    tbl.push_back(mk(1, 0, 0, 1, 0,  1, 1, 3, 0, 1));
    // flashing yellow
    tbl.push_back(mk(1, 0, 0, 0, 1,  1, 4, 3, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 1,  1, 4, 3, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 1,  1, 4, 3, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1,  1, 4, 3, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1,  1, 4, 3, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0,  1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0,  1, 1, 0, 0, 1));
    // freeze mid-green, then flash entry while frozen
    tbl.push_back(mk(1, 0, 0, 0, 0,  3, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 10, 1, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0,  3, 1, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0,  1, 2, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1,  1, 4, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1,  3, 4, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0,  1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0,  1, 1, 0, 0, 1));

    en = 1'b0; ped = '0; emg = 1'b0; eph = '0; fl = 1'b0;
    reset = 1'b0;
    m_reset();
    @(negedge clock);
    @(negedge clock);
    chk("reset_lights4", {20'b0, bus4.lights}, 32'h924);
    chk("reset_state4", {29'b0, bus4.state}, 32'd0);
    chk("reset_model4", act4(), m_out(0));
    chk("reset_model3", act3(), m_out(1));
    en = 1'b1;
    reset = 1'b1;

    foreach (tbl[j]) begin
      en = tbl[j].en; ped = tbl[j].ped; emg = tbl[j].emg; eph = tbl[j].eph; fl = tbl[j].fl;
      repeat (tbl[j].cyc) tick();
      chk($sformatf("vec%0d", j), act4(), pack_exp(4, tbl[j].st, tbl[j].ph, tbl[j].w, tbl[j].tog));
    end
    en = 1'b1; ped = '0; emg = 1'b0; eph = '0; fl = 1'b0;

    // Latched ped request is lost across an asynchronous reset taken during yellow.
    ped = 4'b0010;
    tick();
    ped = '0;
    repeat (6) tick();
    chk("yellow_before_reset", {29'b0, bus4.state}, 32'd2);
    #2 reset = 1'b0;
    m_reset();
    #1;
    chk("async_lights4", {20'b0, bus4.lights}, 32'h924);
    chk("async_lights3", {23'b0, bus3.lights}, 32'h124);
    chk("async_state4", {29'b0, bus4.state}, 32'd0);
    chk("async_walk4", {28'b0, bus4.walk}, 32'd0);
    reset = 1'b1;
    repeat (11) tick();
    chk("ph1_after_reset", {30'b0, bus4.phase_idx}, 32'd1);
    chk("ped_lost_walk", {28'b0, bus4.walk}, 32'd0);

    // Three-phase instance: out-of-range emergency phase is ignored, phase 2 wraps to 0.
    #2 reset = 1'b0;
    m_reset();
    #1 reset = 1'b1;
    emg = 1'b1; eph = 2'd3;
    tick();
    chk("n3_first_green", {29'b0, bus3.state, bus3.phase_idx}, {27'b0, 3'd1, 2'd0});
    repeat (20) tick();
    chk("n3_ph2_green", {23'b0, bus3.lights}, 32'h064);
    chk("n3_ph2_state", {29'b0, bus3.state, bus3.phase_idx}, {27'b0, 3'd1, 2'd2});
    repeat (10) tick();
    chk("n3_wrap", {29'b0, bus3.state, bus3.phase_idx}, {27'b0, 3'd1, 2'd0});
    emg = 1'b0; eph = '0;

    for (int r = 0; r < 3000; r++) begin
      en  = ($urandom_range(0, 9) != 0);
      ped = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0;
      if ($urandom_range(0, 59) == 0) emg = ~emg;
      if ($urandom_range(0, 29) == 0) eph = 2'($urandom);
      if ($urandom_range(0, 199) == 0) fl = ~fl;
      if ($urandom_range(0, 799) == 0) begin
        #2 reset = 1'b0;
        m_reset();
        #1;
        chk("rand_reset4", act4(), m_out(0));
        chk("rand_reset3", act3(), m_out(1));
        reset = 1'b1;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
